// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame transmitter.
// Optional feature: define SERIAL_FRAME_TX_PARITY_EN to append an even-parity bit to every frame.
package serial_pkg;

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} tx_state_t;

  // Number of bit times one frame occupies on the serial line.
  function automatic int frame_len(input int width);
    return width + PAR_BITS;
  endfunction

endpackage

// File: rtl/serial_frame_tx_piso_shift_reg.sv
// WIDTH-bit parallel-load / serial-shift register. Zero-fills on shift and exposes
// the bit that will sit at the output end after this cycle's load or shift.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             head_next
);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;

  // Next register contents: load wins over shift, otherwise hold.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned (no latch).
    sreg_d = sreg_q;
    if (load) begin
      sreg_d = data_in;
    end else if (shift) begin
      sreg_d = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
    end
    head_next = (MSB_FIRST != 0) ? sreg_d[WIDTH-1] : sreg_d[0];
  end

  // Shift register storage.
  always_ff @(posedge clk) begin
    // NOTE: the data register is cleared on reset so no stale word is ever observable after a reset.
    if (reset) begin
      sreg_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      sreg_q <= sreg_d;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: accepts a word over valid/ready and sends it
// one bit per clk on x_out, back-to-back words without idle gaps.
// Optional feature: define SERIAL_FRAME_TX_PARITY_EN to append an even-parity bit.
import serial_pkg::*;

module serial_frame_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int FLEN  = frame_len(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FLEN - 1);
  localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             last_bit;
  logic             accept;
  logic             shift_sr;
  logic             head_next;
  logic             par_bit;

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sreg (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .shift     (shift_sr),
    .data_in   (data_in),
    .head_next (head_next)
  );

`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic par_q;

  // Capture the even parity of each word as it is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^data_in;
    end
  end

  assign par_bit = par_q;
`else
  assign par_bit = 1'b0;
`endif

  // Handshake, next state, bit counter and next serial bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_bit = (state_q != IDLE) && (cnt_q == LAST_CNT);
    load_ready = !reset && ((state_q == IDLE) || last_bit);
    accept   = load_valid && load_ready;
    shift_sr = (state_q == SHIFT);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST_DATA_CNT) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          state_d = PARITY;
          cnt_d   = cnt_q + 1'b1;
`else
          state_d = accept ? SHIFT : IDLE;
          cnt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        state_d = accept ? SHIFT : IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      SHIFT:   x_d = head_next;
      PARITY:  x_d = par_bit;
      default: x_d = 1'b0;
    endcase
  end

  // State, counter and registered serial output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
    end
  end

  assign x_out      = x_q;
  assign bit_valid  = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign frame_done = last_bit;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: three instances (4-bit MSB-first, 4-bit LSB-first,
// 8-bit MSB-first). Status vectors are {x_out, bit_valid, busy, frame_done, load_ready}.
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int F4 = 4 + PB;
  localparam int F8 = 8 + PB;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [3:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready, a_x, a_bv, a_busy, a_fd;
  logic [3:0] b_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_x, b_bv, b_busy, b_fd;
  logic [7:0] c_data = '0;
  logic       c_valid = 1'b0;
  logic       c_ready, c_x, c_bv, c_busy, c_fd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.WIDTH(4), .MSB_FIRST(1)) dut_a (
    .clk(clk), .reset(reset), .data_in(a_data), .load_valid(a_valid), .load_ready(a_ready),
    .x_out(a_x), .bit_valid(a_bv), .busy(a_busy), .frame_done(a_fd));

  serial_frame_tx #(.WIDTH(4), .MSB_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .data_in(b_data), .load_valid(b_valid), .load_ready(b_ready),
    .x_out(b_x), .bit_valid(b_bv), .busy(b_busy), .frame_done(b_fd));

  serial_frame_tx #(.WIDTH(8), .MSB_FIRST(1)) dut_c (
    .clk(clk), .reset(reset), .data_in(c_data), .load_valid(c_valid), .load_ready(c_ready),
    .x_out(c_x), .bit_valid(c_bv), .busy(c_busy), .frame_done(c_fd));

  wire [4:0] a_st = {a_x, a_bv, a_busy, a_fd, a_ready};
  wire [4:0] b_st = {b_x, b_bv, b_busy, b_fd, b_ready};
  wire [4:0] c_st = {c_x, c_bv, c_busy, c_fd, c_ready};

  task automatic test_reset;
    reset = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1;
    a_data = 4'hF; b_data = 4'hF; c_data = 8'hFF;
    repeat (2) @(negedge clk);
    n_vec++; if (a_st !== 5'b00000) begin n_err++; $display("FAIL reset_a got=%b exp=%b", a_st, 5'b00000); end
    n_vec++; if (b_st !== 5'b00000) begin n_err++; $display("FAIL reset_b got=%b exp=%b", b_st, 5'b00000); end
    n_vec++; if (c_st !== 5'b00000) begin n_err++; $display("FAIL reset_c got=%b exp=%b", c_st, 5'b00000); end
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_vec++; if (a_st !== 5'b00001) begin n_err++; $display("FAIL idle_a got=%b exp=%b", a_st, 5'b00001); end
    n_vec++; if (b_st !== 5'b00001) begin n_err++; $display("FAIL idle_b got=%b exp=%b", b_st, 5'b00001); end
    n_vec++; if (c_st !== 5'b00001) begin n_err++; $display("FAIL idle_c got=%b exp=%b", c_st, 5'b00001); end
  endtask

  task automatic test_single_msb;
    logic [0:4] seq = 5'b01111;  // 0111 then parity 1
    logic [4:0] exp;
    @(negedge clk);
    a_data = 4'b0111; a_valid = 1'b1;
    #1;
    n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got=%b exp=1", a_ready); end
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 1; i <= F4; i++) begin
      exp = {seq[i-1], 1'b1, 1'b1, i == F4, i == F4};
      n_vec++; if (a_st !== exp) begin n_err++; $display("FAIL single_bit%0d got=%b exp=%b", i, a_st, exp); end
      @(negedge clk);
    end
    n_vec++; if (a_st !== 5'b00001) begin n_err++; $display("FAIL single_idle got=%b exp=%b", a_st, 5'b00001); end
  endtask

  task automatic test_back_to_back;
    logic [0:9] seq;
    logic [4:0] exp;
    logic       edge_bit;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    seq = 10'b1010_0_0111_1;
`else
    seq = 10'b1010_0111_00;
`endif
    @(negedge clk);
    a_data = 4'b1010; a_valid = 1'b1;
    #1;
    n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b exp=1", a_ready); end
    @(negedge clk);
    a_data = 4'b0111;
    for (int i = 1; i <= 2 * F4; i++) begin
      edge_bit = (i == F4) || (i == 2 * F4);
      exp = {seq[i-1], 1'b1, 1'b1, edge_bit, edge_bit};
      n_vec++; if (a_st !== exp) begin n_err++; $display("FAIL b2b_bit%0d got=%b exp=%b", i, a_st, exp); end
      if (i == 2 * F4) a_valid = 1'b0;
      @(negedge clk);
    end
    n_vec++; if (a_st !== 5'b00001) begin n_err++; $display("FAIL b2b_idle got=%b exp=%b", a_st, 5'b00001); end
  endtask

  task automatic test_lsb_first;
    logic [0:4] seq = 5'b10001;  // 0001 LSB first then parity 1
    logic [4:0] exp;
    @(negedge clk);
    b_data = 4'b0001; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    for (int i = 1; i <= F4; i++) begin
      exp = {seq[i-1], 1'b1, 1'b1, i == F4, i == F4};
      n_vec++; if (b_st !== exp) begin n_err++; $display("FAIL lsb_bit%0d got=%b exp=%b", i, b_st, exp); end
      @(negedge clk);
    end
    n_vec++; if (b_st !== 5'b00001) begin n_err++; $display("FAIL lsb_idle got=%b exp=%b", b_st, 5'b00001); end
  endtask

  task automatic test_reset_mid_frame;
    logic [0:8] seq = 9'b0011_1100_0;  // 8'h3C MSB first then parity 0
    logic [4:0] exp;
    @(negedge clk);
    c_data = 8'hA5; c_valid = 1'b1;
    @(negedge clk);
    c_valid = 1'b0;
    n_vec++; if (c_st !== 5'b11100) begin n_err++; $display("FAIL rst_bit1 got=%b exp=%b", c_st, 5'b11100); end
    @(negedge clk);
    n_vec++; if (c_st !== 5'b01100) begin n_err++; $display("FAIL rst_bit2 got=%b exp=%b", c_st, 5'b01100); end
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (c_st !== 5'b00000) begin n_err++; $display("FAIL rst_abort got=%b exp=%b", c_st, 5'b00000); end
    reset = 1'b0;
    #1;
    n_vec++; if (c_st !== 5'b00001) begin n_err++; $display("FAIL rst_release got=%b exp=%b", c_st, 5'b00001); end
    @(negedge clk);
    n_vec++; if (c_st !== 5'b00001) begin n_err++; $display("FAIL rst_no_resume got=%b exp=%b", c_st, 5'b00001); end
    c_data = 8'h3C; c_valid = 1'b1;
    @(negedge clk);
    c_valid = 1'b0;
    for (int i = 1; i <= F8; i++) begin
      exp = {seq[i-1], 1'b1, 1'b1, i == F8, i == F8};
      n_vec++; if (c_st !== exp) begin n_err++; $display("FAIL rst_3c_bit%0d got=%b exp=%b", i, c_st, exp); end
      @(negedge clk);
    end
    n_vec++; if (c_st !== 5'b00001) begin n_err++; $display("FAIL rst_3c_idle got=%b exp=%b", c_st, 5'b00001); end
  endtask

  task automatic test_no_accept_mid_frame;
    logic [4:0] exp;
    @(negedge clk);
    c_data = 8'h00; c_valid = 1'b1;
    @(negedge clk);
    c_valid = 1'b0;
    for (int i = 1; i <= F8; i++) begin
      exp = {1'b0, 1'b1, 1'b1, i == F8, i == F8};
      n_vec++; if (c_st !== exp) begin n_err++; $display("FAIL busy_bit%0d got=%b exp=%b", i, c_st, exp); end
      if (i == 4) begin c_data = 8'hFF; c_valid = 1'b1; end
      if (i == 5) begin c_data = 8'h00; c_valid = 1'b0; end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (c_st !== 5'b00001) begin n_err++; $display("FAIL busy_idle%0d got=%b exp=%b", k, c_st, 5'b00001); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_msb();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid_frame();
    test_no_accept_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
